tis_node: RTL and testbench

Parametrised second-generation execution node for the tiscomp fabric. It runs a stored program of up to PROG_DEPTH instructions, with a saturating ACC/BAK register pair and full MOV support. MOV, ADD, SUB and JRO operands can come from four directional valid/ready ports (UP, DOWN, LEFT, RIGHT). Nodes tile into a grid: each out port connects to a neighbour's in port.

---
 rtl/tis_node.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_tis_node.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tis_node.sv
// tis_node: stored-program execution node for the tiscomp fabric.
//
// Runs up to PROG_DEPTH 20-bit instructions from the flat 'prog' bus. It has
// a saturating ACC and a BAK register, and four valid/ready ports
// (0=UP 1=DOWN 2=LEFT 3=RIGHT) in each direction.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   prog                 flat program, slot i = prog[20*i +: 20]
//   p_len                active program length (0 = node idle)
//   in_data/in_valid     per-port input data and valid
//   in_ready             per-port input ready (at most one bit high)
//   out_data/out_valid   per-port output data and valid
//   out_ready            per-port output ready
//   pc, acc, bak         architectural state
//   stall_cnt            blocked-cycle counter (only with TIS_STALL_CNT_EN)
//   halted               HCF executed
//
// Optional build macro: TIS_STALL_CNT_EN adds the 16-bit stall_cnt output.

// One output port register. The value is loaded when a port-destination MOV
// issues, and valid is cleared when the neighbour accepts it.
module tis_oport #(
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              done_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (done_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

module tis_node #(
    parameter int  PROG_DEPTH = 15,
    parameter int  DATA_W     = 11,
    parameter int  SAT_MAX    = 999,
    localparam int PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PROG_DEPTH*20-1:0] prog,
    input  logic [PC_W:0]            p_len,
    input  logic [4*DATA_W-1:0]      in_data,
    input  logic [3:0]               in_valid,
    output logic [3:0]               in_ready,
    output logic [4*DATA_W-1:0]      out_data,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic [PC_W-1:0]          pc,
    output logic [DATA_W-1:0]        acc,
    output logic [DATA_W-1:0]        bak,
`ifdef TIS_STALL_CNT_EN
    output logic [15:0]              stall_cnt,
`endif
    output logic                     halted
);
    typedef enum logic [1:0] {S_RUN, S_WRITE, S_HALT} state_e;

    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_JMP  = 3'd4;
    localparam logic [2:0] OP_JRO  = 3'd5;
    localparam logic [2:0] OP_MISC = 3'd6;

    localparam logic signed [DATA_W:0] SMAX = (DATA_W+1)'(SAT_MAX);

    state_e                   state_q, state_d;
    logic [PC_W-1:0]          pc_q, pc_d;
    logic signed [DATA_W-1:0] acc_q, acc_d, bak_q, bak_d;
    logic [1:0]               wport_q, wport_d;

    logic [3:0][DATA_W-1:0]   in_arr, out_arr;
    logic [3:0]               ld, wdone;

    assign in_arr   = in_data;
    assign out_data = out_arr;

    // Instruction fetch; slots past PROG_DEPTH read as NOP.
    logic [19:0] ins;
    always_comb begin
        ins = '0;
        if (32'(pc_q) < PROG_DEPTH) ins = prog[32'(pc_q)*20 +: 20];
    end

    logic [2:0]  op, dst;
    logic        imm;
    logic [12:0] src;
    assign op  = ins[19:17];
    assign imm = ins[16];
    assign dst = ins[15:13];
    assign src = ins[12:0];

    logic unused;
    assign unused = ^src[12:11];

    logic signed [10:0]       imm11;
    logic signed [DATA_W-1:0] imm_val, src_val;
    assign imm11   = src[10:0];
    assign imm_val = DATA_W'(imm11);

    // Port index = code-2, taken modulo 4 on the low two bits (2..5 -> 0..3).
    logic [1:0] sp, dp;
    assign sp = src[1:0] - 2'd2;
    assign dp = dst[1:0] - 2'd2;

    logic uses_src, port_src, run_ok, fire;
    assign uses_src = (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_JRO);
    assign port_src = uses_src && !imm && (src[2:0] >= 3'd2) && (src[2:0] <= 3'd5);
    assign run_ok   = (state_q == S_RUN) && (p_len != '0);
    assign fire     = run_ok && (!port_src || in_valid[sp]);

    always_comb begin
        src_val = '0;
        if (imm) begin
            src_val = imm_val;
        end else begin
            case (src[2:0])
                3'd0:                   src_val = acc_q;
                3'd2, 3'd3, 3'd4, 3'd5: src_val = in_arr[sp];
                default:                src_val = '0;
            endcase
        end
    end

    always_comb begin
        in_ready = '0;
        if (run_ok && port_src) in_ready[sp] = 1'b1;
    end

    // Sequential successor, wrapping at the end of the active program.
    logic [PC_W:0]   plen_m1;
    logic [PC_W-1:0] pc_seq, jmp_tgt, jro_tgt;
    assign plen_m1 = p_len - 1'b1;
    assign pc_seq  = ({1'b0, pc_q} == plen_m1) ? '0 : pc_q + 1'b1;
    assign jmp_tgt = ({1'b0, src[PC_W-1:0]} >= p_len) ? plen_m1[PC_W-1:0] : src[PC_W-1:0];

    logic signed [DATA_W+1:0] jro_sum;
    assign jro_sum = $signed({{(DATA_W+1-PC_W){1'b0}}, pc_q}) + (DATA_W+2)'(src_val);
    always_comb begin
        if (jro_sum < 0)
            jro_tgt = '0;
        else if (jro_sum >= $signed((DATA_W+2)'(p_len)))
            jro_tgt = plen_m1[PC_W-1:0];
        else
            jro_tgt = jro_sum[PC_W-1:0];
    end

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
        if (v > SMAX)       return SMAX[DATA_W-1:0];
        else if (v < -SMAX) return DATA_W'(-SMAX);
        else                return v[DATA_W-1:0];
    endfunction

    // Sum taken one bit wider than the operands so it cannot wrap before clamping.
    logic signed [DATA_W:0] alu_sum;
    assign alu_sum = (op == OP_SUB) ? (DATA_W+1)'(acc_q) - (DATA_W+1)'(src_val)
                                    : (DATA_W+1)'(acc_q) + (DATA_W+1)'(src_val);

    logic take;
    always_comb begin
        case (dst)
            3'd0:    take = 1'b1;
            3'd1:    take = (acc_q == 0);
            3'd2:    take = (acc_q != 0);
            3'd3:    take = (acc_q > 0);
            3'd4:    take = (acc_q < 0);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        bak_d   = bak_q;
        wport_d = wport_q;
        ld      = '0;
        wdone   = '0;
        case (state_q)
            S_RUN: begin
                if (fire) begin
                    pc_d = pc_seq;
                    case (op)
                        OP_MOV: begin
                            case (dst)
                                3'd0: acc_d = sat((DATA_W+1)'(src_val));
                                3'd2, 3'd3, 3'd4, 3'd5: begin
                                    // pc holds until the neighbour takes the word
                                    ld[dp]  = 1'b1;
                                    wport_d = dp;
                                    state_d = S_WRITE;
                                    pc_d    = pc_q;
                                end
                                default: ;
                            endcase
                        end
                        OP_ADD, OP_SUB: acc_d = sat(alu_sum);
                        OP_JMP: if (take) pc_d = jmp_tgt;
                        OP_JRO: pc_d = jro_tgt;
                        OP_MISC: begin
                            case (dst)
                                3'd0: begin
                                    acc_d = bak_q;
                                    bak_d = acc_q;
                                end
                                3'd1: bak_d = acc_q;
                                3'd2: acc_d = -acc_q;
                                3'd3: begin
                                    state_d = S_HALT;
                                    pc_d    = pc_q;
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: begin
                if (out_ready[wport_q]) begin
                    wdone[wport_q] = 1'b1;
                    pc_d           = pc_seq;
                    state_d        = S_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            acc_q   <= '0;
            bak_q   <= '0;
            wport_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            bak_q   <= bak_d;
            wport_q <= wport_d;
        end
    end

    for (genvar p = 0; p < 4; p++) begin : g_oport
        tis_oport #(.DATA_W(DATA_W)) u_oport (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (ld[p]),
            .data_i  (src_val),
            .done_i  (wdone[p]),
            .data_o  (out_arr[p]),
            .valid_o (out_valid[p])
        );
    end

`ifdef TIS_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic        blocked;
    assign blocked = (run_ok && port_src && !in_valid[sp]) ||
                     ((state_q == S_WRITE) && !out_ready[wport_q]);
    assign stall_d = (blocked && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end
    assign stall_cnt = stall_q;
`endif

    assign pc     = pc_q;
    assign acc    = acc_q;
    assign bak    = bak_q;
    assign halted = (state_q == S_HALT);
endmodule

// File: tb/tb_tis_node.sv
// Testbench for tis_node: directed scenarios plus randomized forward-flowing
// programs compared with an instruction-level model. Expected output-port
// words go into a queue and are popped by an independent port monitor.
module tb_tis_node;
    localparam int PROG_DEPTH = 15;
    localparam int DATA_W     = 11;
    localparam int PC_W       = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [PROG_DEPTH*20-1:0] prog = '0;
    logic [PC_W:0]            p_len = '0;
    logic [3:0][DATA_W-1:0]   in_d = '0;
    logic [3:0]               in_valid = '0;
    logic [3:0]               in_ready;
    logic [3:0][DATA_W-1:0]   od;
    logic [3:0]               out_valid;
    logic [3:0]               out_ready = '0;
    logic [PC_W-1:0]          pc;
    logic [DATA_W-1:0]        acc, bak;
    logic                     halted;
`ifdef TIS_STALL_CNT_EN
    logic [15:0]              stall_cnt;
`endif

    tis_node #(.PROG_DEPTH(PROG_DEPTH), .DATA_W(DATA_W), .SAT_MAX(999)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog      (prog),
        .p_len     (p_len),
        .in_data   (in_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (od),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc        (pc),
        .acc       (acc),
        .bak       (bak),
`ifdef TIS_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct { int port; int data; } xfer_t;
    xfer_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    int f_op[16], f_imm[16], f_dst[16], f_src[16], f_val[16];
    int ival[4][16];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output-port monitor: every accepted word must match the queue head.
    always @(negedge clk) begin
        xfer_t e;
        if (rst_n) begin
            for (int p = 0; p < 4; p++) begin
                if (out_valid[p] && out_ready[p]) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL xfer_unexpected: port %0d data %0d, none expected",
                                 p, int'($signed(od[p])));
                    end else begin
                        e = exp_q.pop_front();
                        if (e.port != p || e.data != int'($signed(od[p]))) begin
                            n_fail++;
                            $display("FAIL xfer: got port %0d data %0d, expected port %0d data %0d",
                                     p, int'($signed(od[p])), e.port, e.data);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [19:0] enc(input int op, input int imm, input int dst, input int src);
        return {3'(op), 1'(imm), 3'(dst), 13'(src)};
    endfunction

    function automatic int satf(input int x);
        return (x > 999) ? 999 : (x < -999) ? -999 : x;
    endfunction

    task automatic set_slot(input int i, input logic [19:0] w);
        prog[20*i +: 20] = w;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_test();
        int L, pc_m, a, b, v, npc, s, steps, cyc;
        int k[4];
        int idx[4];
        bit done;
        logic [3:0] hs;
        prog = '0;
        L = $urandom_range(4, PROG_DEPTH);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++) ival[i][j] = int'($urandom_range(0, 1998)) - 999;
        for (int i = 0; i < L - 1; i++) begin
            f_imm[i] = 0; f_dst[i] = 0; f_src[i] = 0; f_val[i] = 0;
            case ($urandom_range(0, 6))
                0: f_op[i] = ($urandom_range(0, 1) == 0) ? 0 : 7;
                1, 2, 3: begin
                    f_op[i]  = $urandom_range(1, 3);
                    f_imm[i] = $urandom_range(0, 1);
                    f_dst[i] = $urandom_range(0, 7);
                    f_src[i] = $urandom_range(0, 7);
                    f_val[i] = int'($urandom_range(0, 1998)) - 999;
                end
                4: begin
                    f_op[i]  = 4;
                    f_dst[i] = $urandom_range(0, 7);
                    f_src[i] = i + int'($urandom_range(1, 6));
                    if (f_src[i] > 15) f_src[i] = 15;
                end
                5: begin
                    f_op[i]  = 5;
                    f_imm[i] = 1;
                    f_val[i] = $urandom_range(1, 20);
                end
                default: begin
                    f_op[i]  = 6;
                    f_dst[i] = $urandom_range(0, 6);
                    if (f_dst[i] >= 3) f_dst[i]++;
                end
            endcase
        end
        f_op[L-1] = 6; f_imm[L-1] = 0; f_dst[L-1] = 3; f_src[L-1] = 0; f_val[L-1] = 0;
        for (int i = 0; i < L; i++)
            set_slot(i, enc(f_op[i], f_imm[i], f_dst[i], (f_imm[i] != 0) ? f_val[i] : f_src[i]));

        // Instruction-level reference run: ports deliver their lists in order.
        pc_m = 0; a = 0; b = 0; done = 0; steps = 0;
        for (int i = 0; i < 4; i++) k[i] = 0;
        while (!done && steps < 200) begin
            steps++;
            v = 0;
            if (f_op[pc_m] inside {1, 2, 3, 5}) begin
                if (f_imm[pc_m] != 0) v = f_val[pc_m];
                else begin
                    s = f_src[pc_m];
                    if (s == 0) v = a;
                    else if (s >= 2 && s <= 5) begin
                        v = ival[s-2][k[s-2]];
                        k[s-2]++;
                    end
                end
            end
            npc = (pc_m == L - 1) ? 0 : pc_m + 1;
            case (f_op[pc_m])
                1: begin
                    if (f_dst[pc_m] == 0) a = satf(v);
                    else if (f_dst[pc_m] >= 2 && f_dst[pc_m] <= 5)
                        exp_q.push_back('{f_dst[pc_m] - 2, v});
                end
                2: a = satf(a + v);
                3: a = satf(a - v);
                4: begin
                    if ((f_dst[pc_m] == 0) || (f_dst[pc_m] == 1 && a == 0) ||
                        (f_dst[pc_m] == 2 && a != 0) || (f_dst[pc_m] == 3 && a > 0) ||
                        (f_dst[pc_m] == 4 && a < 0))
                        npc = (f_src[pc_m] >= L) ? L - 1 : f_src[pc_m];
                end
                5: begin
                    npc = pc_m + v;
                    if (npc < 0) npc = 0;
                    if (npc > L - 1) npc = L - 1;
                end
                6: begin
                    case (f_dst[pc_m])
                        0: begin s = a; a = b; b = s; end
                        1: b = a;
                        2: a = -a;
                        3: begin done = 1; npc = pc_m; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
            pc_m = npc;
        end

        p_len = (PC_W+1)'(L);
        do_reset();
        for (int i = 0; i < 4; i++) idx[i] = 0;
        cyc = 0;
        while (!halted && cyc < 2000) begin
            @(negedge clk);
            hs = in_valid & in_ready;
            @(posedge clk);
            #1 cyc++;
            for (int p = 0; p < 4; p++) begin
                if (hs[p]) begin
                    idx[p]++;
                    in_valid[p] = 1'b0;
                end
                if (!in_valid[p] && idx[p] < 16 && $urandom_range(0, 2) == 0) begin
                    in_d[p] = DATA_W'(ival[p][idx[p]]);
                    in_valid[p] = 1'b1;
                end
            end
            out_ready = 4'($urandom);
        end
        chk("rnd_halted", int'(halted), 1);
        chk("rnd_pc", int'(pc), pc_m);
        chk("rnd_acc", int'($signed(acc)), a);
        chk("rnd_bak", int'($signed(bak)), b);
        chk("rnd_xfer_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        // Reset state, held asynchronously.
        set_slot(0, enc(1, 0, 0, 2));
        p_len = 5'd0;
        #12;
        chk("rst_pc", int'(pc), 0);
        chk("rst_acc", int'(acc), 0);
        chk("rst_bak", int'(bak), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data_zero", int'(od == '0), 1);

        // p_len == 0: node idles even though slot 0 reads a port.
        do_reset();
        repeat (3) step();
        chk("plen0_pc", int'(pc), 0);
        chk("plen0_in_ready", int'(in_ready), 0);

        // ADD 600; ADD 600; SUB 5 with saturation and wrap.
        prog = '0;
        set_slot(0, enc(2, 1, 0, 600));
        set_slot(1, enc(2, 1, 0, 600));
        set_slot(2, enc(3, 1, 0, 5));
        p_len = 5'd3;
        do_reset();
        step(); chk("add1_acc", int'($signed(acc)), 600); chk("add1_pc", int'(pc), 1);
        step(); chk("add2_acc", int'($signed(acc)), 999); chk("add2_pc", int'(pc), 2);
        step(); chk("sub_acc", int'($signed(acc)), 994);  chk("sub_pc", int'(pc), 0);

        // MOV UP,ACC with the neighbour late by four cycles.
        prog = '0;
        set_slot(0, enc(1, 0, 0, 2));
        p_len = 5'd2;
        do_reset();
        in_d[0] = DATA_W'(-42);
        for (int c = 1; c <= 4; c++) begin
            chk("up_wait_ready", int'(in_ready), 1);
            step();
        end
        in_valid[0] = 1'b1;
        chk("up_hs_ready", int'(in_ready), 1);
        step();
        in_valid[0] = 1'b0;
        chk("up_acc", int'($signed(acc)), -42);
        chk("up_pc", int'(pc), 1);
        chk("up_ready_after", int'(in_ready), 0);
`ifdef TIS_STALL_CNT_EN
        chk("up_stall_cnt", int'(stall_cnt), 4);
`endif

        // MOV 7,RIGHT with out_ready held low for three cycles.
        prog = '0;
        set_slot(0, enc(1, 1, 5, 7));
        p_len = 5'd2;
        do_reset();
        exp_q.push_back('{3, 7});
        step();
        repeat (3) begin
            chk("right_valid", int'(out_valid), 8);
            chk("right_data", int'($signed(od[3])), 7);
            chk("right_pc_held", int'(pc), 0);
            chk("right_no_ready", int'(in_ready), 0);
            step();
        end
        out_ready[3] = 1'b1;
        step();
        out_ready = '0;
        chk("right_pc_adv", int'(pc), 1);
        chk("right_valid_clr", int'(out_valid), 0);
        chk("right_popped", exp_q.size(), 0);
`ifdef TIS_STALL_CNT_EN
        chk("right_stall_cnt", int'(stall_cnt), 3);
`endif

        // Reset in the middle of a port write abandons it.
        prog = '0;
        set_slot(0, enc(1, 1, 2, 123));
        p_len = 5'd1;
        do_reset();
        step();
        chk("wr_up_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("wr_abort_valid", int'(out_valid), 0);
        chk("wr_abort_data", int'(od == '0), 1);

        // MOV 5,ACC; SAV; NEG; SWP.
        prog = '0;
        set_slot(0, enc(1, 1, 0, 5));
        set_slot(1, enc(6, 0, 1, 0));
        set_slot(2, enc(6, 0, 2, 0));
        set_slot(3, enc(6, 0, 0, 0));
        p_len = 5'd4;
        do_reset();
        step(); chk("mov_acc", int'($signed(acc)), 5);
        step(); chk("sav_bak", int'($signed(bak)), 5);
        step(); chk("neg_acc", int'($signed(acc)), -5);
        step(); chk("swp_acc", int'($signed(acc)), 5); chk("swp_bak", int'($signed(bak)), -5);

        // JRO -20 at pc 2 clamps to 0.
        prog = '0;
        set_slot(2, enc(5, 1, 0, -20));
        p_len = 5'd4;
        do_reset();
        step(); step(); chk("jro_pre_pc", int'(pc), 2);
        step(); chk("jro_neg_pc", int'(pc), 0);

        // JRO +20 clamps to p_len-1.
        prog = '0;
        set_slot(0, enc(5, 1, 0, 20));
        do_reset();
        step(); chk("jro_pos_pc", int'(pc), 3);

        // JNZ with acc 0 falls through; JEZ then takes.
        prog = '0;
        set_slot(0, enc(4, 0, 2, 3));
        set_slot(1, enc(4, 0, 1, 3));
        do_reset();
        step(); chk("jnz_fall_pc", int'(pc), 1);
        step(); chk("jez_take_pc", int'(pc), 3);

        // HCF at pc 1, then asynchronous reset during HALT.
        prog = '0;
        set_slot(1, enc(6, 0, 3, 0));
        p_len = 5'd3;
        do_reset();
        step(); chk("hcf_pre_pc", int'(pc), 1);
        step(); chk("hcf_halted", int'(halted), 1);
        in_valid = 4'hF;
        out_ready = 4'hF;
        repeat (3) step();
        chk("halt_pc", int'(pc), 1);
        chk("halt_still", int'(halted), 1);
        chk("halt_in_ready", int'(in_ready), 0);
        chk("halt_out_valid", int'(out_valid), 0);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_halted", int'(halted), 0);
        chk("halt_rst_pc", int'(pc), 0);
        chk("halt_rst_acc", int'(acc), 0);
        in_valid = '0;
        out_ready = '0;

        // Randomized programs against the reference model.
        for (int t = 0; t < 25; t++) rand_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
